// File: rtl/discrete_osc_pkg.sv
// Shared definitions for the discrete oscillator blocks: state encoding,
// RC time constants and the RC-to-clock-count conversion.
package discrete_osc_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FIRST_HIGH = 2'd1,
        HIGH       = 2'd2,
        LOW        = 2'd3
    } osc_state_t;

    // ln(2) and ln(3), scaled by 1000
    localparam longint LN2_X1000 = 64'sd693;
    localparam longint LN3_X1000 = 64'sd1100;

    // clocks = clock_rate * k * R * C[nF] / 10^12, divided last to keep precision; never below 1
    function automatic longint rc_to_clocks(input longint clock_rate,
                                            input longint k_x1000,
                                            input longint r_ohm,
                                            input longint c_nf);
        longint v;
        v = (clock_rate * k_x1000 * r_ohm * c_nf) / 64'sd1_000_000_000_000;
        if (v < 64'sd1) v = 64'sd1;
        return v;
    endfunction

endpackage

// File: rtl/asymmetric_slew_limiter.sv
// Moves a signed sample toward its target on each audio strobe, limited to
// RISE_STEP upward and FALL_STEP downward per strobe, never overshooting.
module asymmetric_slew_limiter #(
    parameter int RISE_STEP = 1024,
    parameter int FALL_STEP = 2048
) (
    input  logic               clk,
    input  logic               I_RST,
    input  logic               audio_clk_en,
    input  logic signed [15:0] in,
    output logic signed [15:0] out
);

    localparam logic signed [16:0] RISE_S = 17'(RISE_STEP);
    localparam logic signed [16:0] FALL_S = 17'(FALL_STEP);

    logic signed [15:0] out_q, out_d;
    logic signed [16:0] diff;
    logic signed [16:0] next_wide;

    // Step toward the target by at most the rate limit for that direction
    always_comb begin
        diff      = {in[15], in} - {out_q[15], out_q};
        next_wide = {out_q[15], out_q};
        if (audio_clk_en) begin
            if (diff > 17'sd0) begin
                next_wide = (diff > RISE_S) ? next_wide + RISE_S : next_wide + diff;
            end else if (diff < 17'sd0) begin
                next_wide = (-diff > FALL_S) ? next_wide - FALL_S : next_wide + diff;
            end
        end
        out_d = next_wide[15:0];
    end

    // Sample register
    always_ff @(posedge clk) begin
        if (I_RST) out_q <= '0;
        else       out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: rtl/gated_astable_square_oscillator.sv
// Gated 555-style astable: stretched first high phase after the gate opens,
// then alternating high/low phases, followed by a slew-limited audio output.
//
//  state      | meaning
//  IDLE       | gate closed, output held low
//  FIRST_HIGH | first high phase, capacitor charging from 0V (longer)
//  HIGH       | steady-state high phase
//  LOW        | discharge phase
module gated_astable_square_oscillator
    import discrete_osc_pkg::*;
#(
    parameter longint CLOCK_RATE  = 50000000,
    parameter int     SAMPLE_RATE = 48000,
    parameter int     R1          = 10000,
    parameter int     R2          = 10000,
    parameter int     C_NF        = 100,
    parameter int     VCC         = 12,
    parameter int     V_SIGNAL    = 5,
    parameter int     RISE_STEP   = 1024,
    parameter int     FALL_STEP   = 2048
) (
    input  logic               clk,
    input  logic               I_RST,
    input  logic               audio_clk_en,
    input  logic               gate,
    output logic               level,
    output logic signed [15:0] out
);

    localparam longint T_HIGH  = rc_to_clocks(CLOCK_RATE, LN2_X1000, longint'(R1) + longint'(R2), longint'(C_NF));
    localparam longint T_LOW   = rc_to_clocks(CLOCK_RATE, LN2_X1000, longint'(R2), longint'(C_NF));
    localparam longint T_FIRST = rc_to_clocks(CLOCK_RATE, LN3_X1000, longint'(R1) + longint'(R2), longint'(C_NF));

    localparam longint MAX_T = 64'sd4294967295;

    if (T_HIGH > MAX_T || T_LOW > MAX_T || T_FIRST > MAX_T) begin : g_range_err
        $error("phase length does not fit the 32-bit counter");
    end

    if (SAMPLE_RATE <= 0 || longint'(SAMPLE_RATE) > CLOCK_RATE) begin : g_rate_err
        $error("SAMPLE_RATE must be positive and not above CLOCK_RATE");
    end

    localparam logic [31:0] T_HIGH_M1  = 32'(T_HIGH - 64'sd1);
    localparam logic [31:0] T_LOW_M1   = 32'(T_LOW - 64'sd1);
    localparam logic [31:0] T_FIRST_M1 = 32'(T_FIRST - 64'sd1);

    localparam logic signed [15:0] OUT_HIGH = 16'((V_SIGNAL <<< 14) / VCC);

    osc_state_t         state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               level_q, level_d;
    logic signed [15:0] target;

    // Next-state: gate low forces IDLE ahead of any terminal count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        if (!gate) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FIRST_HIGH;
                    cnt_d   = '0;
                end
                FIRST_HIGH: begin
                    if (cnt_q == T_FIRST_M1) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end
                end
                HIGH: begin
                    if (cnt_q == T_HIGH_M1) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end
                end
                LOW: begin
                    if (cnt_q == T_LOW_M1) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        level_d = (state_d == FIRST_HIGH) || (state_d == HIGH);
    end

    // State, phase counter and level registers
    always_ff @(posedge clk) begin
        if (I_RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level  = level_q;
    assign target = level_q ? OUT_HIGH : 16'sd0;

    asymmetric_slew_limiter #(
        .RISE_STEP (RISE_STEP),
        .FALL_STEP (FALL_STEP)
    ) u_slew (
        .clk          (clk),
        .I_RST        (I_RST),
        .audio_clk_en (audio_clk_en),
        .in           (target),
        .out          (out)
    );

endmodule

// File: tb/tb_gated_astable_square_oscillator.sv
// Directed bench for the gated astable oscillator with a 1 MHz clock:
// first high 2200, high 1386, low 693 clocks, high level 6826.
module tb_gated_astable_square_oscillator;

    logic               clk = 1'b0;
    logic               I_RST = 1'b1;
    logic               audio_clk_en = 1'b0;
    logic               gate = 1'b0;
    logic               level;
    logic signed [15:0] out;

    int errors = 0;
    int checks = 0;

    localparam int T_FIRST  = 2200;
    localparam int T_HIGH   = 1386;
    localparam int T_LOW    = 693;
    localparam int OUT_HIGH = 6826;
    localparam int RUN_MAX  = 10000;

    gated_astable_square_oscillator #(
        .CLOCK_RATE  (1000000),
        .SAMPLE_RATE (48000),
        .R1          (1000),
        .R2          (1000),
        .C_NF        (1000),
        .VCC         (12),
        .V_SIGNAL    (5),
        .RISE_STEP   (1024),
        .FALL_STEP   (2048)
    ) dut (
        .clk          (clk),
        .I_RST        (I_RST),
        .audio_clk_en (audio_clk_en),
        .gate         (gate),
        .level        (level),
        .out          (out)
    );

    always #5 clk = ~clk;

    // Clock reset in with gate closed; inputs change on falling edges
    task automatic do_reset();
        @(negedge clk);
        I_RST = 1'b1;
        gate = 1'b0;
        audio_clk_en = 1'b0;
        repeat (2) @(negedge clk);
        I_RST = 1'b0;
    endtask

    // Count consecutive falling edges on which level holds val, bounded
    task automatic count_run(input logic val, output int n);
        n = 0;
        while (level === val && n < RUN_MAX) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Wait 19 idle clocks then give a one-clock strobe; out is sampled after it
    task automatic strobe_after_gap();
        repeat (19) @(negedge clk);
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        I_RST = 1'b1;
        gate = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (level !== 1'b0 || out !== 16'sd0) begin
            errors++;
            $display("FAIL reset_state: level=%0b out=%0d, need level=0 out=0", level, out);
        end
        I_RST = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            audio_clk_en = (i % 20 == 19);
            @(negedge clk);
            checks++;
            if (level !== 1'b0 || out !== 16'sd0) begin
                errors++;
                $display("FAIL gate_low_hold clk %0d: level=%0b out=%0d, need 0/0", i, level, out);
            end
        end
        audio_clk_en = 1'b0;
    endtask

    task automatic test_oscillation();
        int n;
        do_reset();
        gate = 1'b1;
        checks++;
        if (level !== 1'b0) begin
            errors++;
            $display("FAIL osc_pre_edge: level=%0b, need 0", level);
        end
        @(negedge clk);
        checks++;
        if (level !== 1'b1) begin
            errors++;
            $display("FAIL osc_rise_latency: level=%0b, need 1", level);
        end
        count_run(1'b1, n);
        checks++;
        if (n !== T_FIRST) begin errors++; $display("FAIL first_high_len: got %0d need %0d", n, T_FIRST); end
        for (int k = 0; k < 2; k++) begin
            count_run(1'b0, n);
            checks++;
            if (n !== T_LOW) begin errors++; $display("FAIL low_len[%0d]: got %0d need %0d", k, n, T_LOW); end
            count_run(1'b1, n);
            checks++;
            if (n !== T_HIGH) begin errors++; $display("FAIL high_len[%0d]: got %0d need %0d", k, n, T_HIGH); end
        end
        count_run(1'b0, n);
        checks++;
        if (n !== T_LOW) begin errors++; $display("FAIL low_len[2]: got %0d need %0d", n, T_LOW); end
    endtask

    task automatic test_slew();
        int rise_exp[9] = '{1024, 2048, 3072, 4096, 5120, 6144, 6826, 6826, 6826};
        int fall_exp[5] = '{4778, 2730, 682, 0, 0};
        int n;
        do_reset();
        gate = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            strobe_after_gap();
            checks++;
            if (out !== 16'(rise_exp[i])) begin
                errors++;
                $display("FAIL slew_rise[%0d]: out=%0d need %0d", i, out, rise_exp[i]);
            end
        end
        n = 0;
        while (level !== 1'b0 && n < RUN_MAX) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (level !== 1'b0) begin errors++; $display("FAIL slew_wait_low: level=%0b need 0", level); end
        for (int i = 0; i < 5; i++) begin
            strobe_after_gap();
            checks++;
            if (out !== 16'(fall_exp[i])) begin
                errors++;
                $display("FAIL slew_fall[%0d]: out=%0d need %0d", i, out, fall_exp[i]);
            end
        end
    endtask

    task automatic test_gate_drop();
        int n;
        do_reset();
        gate = 1'b1;
        @(negedge clk);
        count_run(1'b1, n);
        count_run(1'b0, n);
        checks++;
        if (level !== 1'b1) begin errors++; $display("FAIL drop_in_high: level=%0b need 1", level); end
        repeat (99) @(negedge clk);
        gate = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== 1'b0) begin errors++; $display("FAIL drop_level: level=%0b need 0", level); end
        repeat (49) @(negedge clk);
        checks++;
        if (level !== 1'b0) begin errors++; $display("FAIL drop_hold: level=%0b need 0", level); end
        gate = 1'b1;
        @(negedge clk);
        count_run(1'b1, n);
        checks++;
        if (n !== T_FIRST) begin errors++; $display("FAIL regate_first_len: got %0d need %0d", n, T_FIRST); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        gate = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) strobe_after_gap();
        checks++;
        if (out !== 16'(OUT_HIGH)) begin errors++; $display("FAIL mid_pre_out: out=%0d need %0d", out, OUT_HIGH); end
        I_RST = 1'b1;
        audio_clk_en = 1'b1;
        @(negedge clk);
        I_RST = 1'b0;
        audio_clk_en = 1'b0;
        checks++;
        if (out !== 16'sd0 || level !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: level=%0b out=%0d, need 0/0", level, out);
        end
        @(negedge clk);
        count_run(1'b1, n);
        checks++;
        if (n !== T_FIRST) begin errors++; $display("FAIL mid_restart_len: got %0d need %0d", n, T_FIRST); end
    endtask

    task automatic test_tc_gate();
        int n;
        do_reset();
        gate = 1'b1;
        @(negedge clk);
        repeat (T_FIRST - 1) @(negedge clk);
        checks++;
        if (level !== 1'b1) begin errors++; $display("FAIL tc_last_high: level=%0b need 1", level); end
        gate = 1'b0;
        @(negedge clk);
        gate = 1'b1;
        checks++;
        if (level !== 1'b0) begin errors++; $display("FAIL tc_gate_level: level=%0b need 0", level); end
        @(negedge clk);
        checks++;
        if (level !== 1'b1) begin errors++; $display("FAIL tc_gate_restart: level=%0b need 1", level); end
        count_run(1'b1, n);
        checks++;
        if (n !== T_FIRST) begin errors++; $display("FAIL tc_gate_first_len: got %0d need %0d", n, T_FIRST); end
    endtask

    initial begin
        test_reset();
        test_oscillation();
        test_slew();
        test_gate_drop();
        test_reset_mid();
        test_tc_gate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
